// File: rtl/serial_slice_adder_pkg.sv
// rtl/serial_slice_adder_pkg.sv - shared state encoding and slice-count helper for serial_slice_adder
package serial_slice_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Returns the number of RUN cycles, or 0 when the width/slice pair is illegal.
    function automatic int num_slices(input int width, input int slice);
        if (slice < 1 || width < slice || (width % slice) != 0) begin
            return 0;
        end
        return width / slice;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SLICE-bit ripple of full adders
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic c;

    // c is rewritten bit by bit so the ripple stays a plain chain without a feedback vector.
    always_comb begin
        c    = cin;
        cmsb = cin;
        s    = '0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                cmsb = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_slice_adder.sv
// rtl/serial_slice_adder.sv - slice-serial A+B+Cin adder with start/done handshake; SERIAL_SLICE_ADDER_SUB_EN adds the Sub port
module serial_slice_adder
    import serial_slice_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_SLICE_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);

    localparam int N  = num_slices(WIDTH, SLICE);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (N == 0) begin : g_illegal_params
            $error("serial_slice_adder: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;

`ifdef SERIAL_SLICE_ADDER_SUB_EN
    // Two's-complement subtract: invert B and inject the +1 through the carry.
    assign b_in   = Sub ? ~B : B;
    assign cin_in = Sub | Cin;
`else
    assign b_in   = B;
    assign cin_in = Cin;
`endif

    logic [SLICE-1:0]       s_slice;
    logic                   c_out;
    logic                   c_msb;
    logic [WIDTH+SLICE-1:0] sum_cat;
    logic                   last;

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (a_sh[SLICE-1:0]),
        .b    (b_sh[SLICE-1:0]),
        .cin  (carry_q),
        .s    (s_slice),
        .cout (c_out),
        .cmsb (c_msb)
    );

    // Operands shift down and results shift in from the top, so after N
    // cycles slice k sits at Sum[k*SLICE +: SLICE] without any index muxing.
    assign sum_cat = {s_slice, sum_q};
    assign last    = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= A;
                        b_sh    <= b_in;
                        carry_q <= cin_in;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> SLICE;
                    b_sh    <= b_sh >> SLICE;
                    sum_q   <= sum_cat[WIDTH+SLICE-1:SLICE];
                    carry_q <= c_out;
                    if (last) begin
                        ovf_q <= c_msb ^ c_out;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready    = (state == IDLE);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign Sum      = sum_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// tb/tb_serial_slice_adder.sv - scoreboard bench for serial_slice_adder (default and WIDTH=SLICE=1)
module tb_serial_slice_adder;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          ready, busy, done, carry, ovf;
    logic [W-1:0]  sum;

    logic          start1, a1, b1, cin1;
    logic          ready1, busy1, done1, sum1, carry1, ovf1;

    always #5 clk = ~clk;

    serial_slice_adder #(.WIDTH(W), .SLICE(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (a),
        .B        (b),
        .Cin      (cin),
`ifdef SERIAL_SLICE_ADDER_SUB_EN
        .Sub      (sub),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .Sum      (sum),
        .Carry    (carry),
        .Overflow (ovf)
    );

    serial_slice_adder #(.WIDTH(1), .SLICE(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .A        (a1),
        .B        (b1),
        .Cin      (cin1),
`ifdef SERIAL_SLICE_ADDER_SUB_EN
        .Sub      (1'b0),
`endif
        .ready    (ready1),
        .busy     (busy1),
        .done     (done1),
        .Sum      (sum1),
        .Carry    (carry1),
        .Overflow (ovf1)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv, input int acc);
        exp_t         r;
        logic [W:0]   t;
        logic [W-1:0] bb;
        logic         cc;
        bb      = sv ? ~bv : bv;
        cc      = sv ? 1'b1 : cv;
        t       = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, cc};
        r.sum   = t[W-1:0];
        r.carry = t[W];
        r.ovf   = (av[W-1] == bb[W-1]) && (t[W-1] != av[W-1]);
        r.acc   = acc;
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", {16'd0, sum}, {16'd0, e.sum});
                check("carry", {31'd0, carry}, {31'd0, e.carry});
                check("overflow", {31'd0, ovf}, {31'd0, e.ovf});
                check("latency", cyc - e.acc, N);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv, input bit push);
        int budget;
        budget = 0;
        while (ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (push) sb.push_back(model(av, bv, cv, sv, cyc));
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        int tot;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-adder truth table on the single-slice instance.
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0];
            check("n1_ready", {31'd0, ready1}, 32'd1);
            start1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            @(negedge clk);
            tot = i[2] + i[1] + i[0];
            check("n1_done", {31'd0, done1}, 32'd1);
            check("n1_sum", {31'd0, sum1}, tot % 2);
            check("n1_carry", {31'd0, carry1}, tot / 2);
            @(negedge clk);
        end

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_ready", {31'd0, ready}, 32'd0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);

        // start held high with other operands during a running operation
        issue(16'h00F0, 16'h000F, 1'b0, 1'b0, 1'b1);
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1);
        end
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset in the second RUN cycle of an operation that never completes.
        issue(16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_carry", {31'd0, carry}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {31'd0, ready}, 32'd1);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

`ifdef SERIAL_SLICE_ADDER_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        issue(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
`endif
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
